// File: rtl/loader_pkg.sv
// Shared state encoding and default geometry for the program loader.
package loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_EVAL,
    S_RUN,
    S_ERROR
  } loader_state_t;

  localparam int         LOADER_DEPTH     = 16;
  localparam int         LOADER_AW        = 4;
  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/loader_gap_timer.sv
// Idle-gap counter for the loader; compiled only with LOADER_TIMEOUT_EN defined.
// Expires on the LIMIT-th consecutive enabled cycle without a clear.
`ifdef LOADER_TIMEOUT_EN
module loader_gap_timer #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear || !i_enable) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_enable && (r_cnt == LAST);
endmodule
`endif

// File: rtl/program_loader.sv
// Framed byte-stream loader: SYNC, DEPTH data bytes, checksum; writes CPU memory one cycle
// after each accepted data byte and releases cpu_run on a good checksum. Gap timeout: LOADER_TIMEOUT_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int         DEPTH          = LOADER_DEPTH,
  parameter int         AW             = LOADER_AW,
  parameter logic [7:0] SYNC_BYTE      = LOADER_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          cpu_run,
  output logic          busy,
  output logic          load_ok,
  output logic          load_err,
  output logic [AW:0]   byte_count
);
  localparam logic [AW:0] LAST_IDX = (AW + 1)'(DEPTH - 1);

  loader_state_t r_state, w_next;

  logic [7:0]    r_sum;
  logic [7:0]    r_chk;
  logic [AW:0]   r_count;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [7:0]    r_mem_wdata;
  logic          r_ok;
  logic          r_err;

  logic w_ready;
  logic w_accept;
  logic w_start;
  logic w_load_byte;
  logic w_abort;
  logic w_busy;
  logic w_match;
  logic w_gap_en;
  logic w_timeout;

  // EVAL is the only state that refuses input; reset also holds the source off.
  assign w_ready  = (r_state != S_EVAL);
  assign in_ready = w_ready && !rst;
  assign w_accept = in_valid && in_ready;
  assign w_match  = (r_sum == r_chk);
  assign w_gap_en = (r_state == S_LOAD) || (r_state == S_CHECK);

`ifdef LOADER_TIMEOUT_EN
  loader_gap_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_accept),
    .i_enable (w_gap_en),
    .o_expired(w_timeout)
  );
`else
  // Limit is meaningless without the timer; referenced only to keep it visible in the netlist.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0) && w_gap_en;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_load_byte = 1'b0;
    w_abort     = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (w_accept && (in_data == SYNC_BYTE)) begin
          w_next  = S_LOAD;
          w_start = 1'b1;
        end
      end
      S_LOAD: begin
        w_busy = 1'b1;
        if (w_accept) begin
          w_load_byte = 1'b1;
          if (r_count == LAST_IDX) begin
            w_next = S_CHECK;
          end
        end else if (w_timeout) begin
          w_next  = S_ERROR;
          w_abort = 1'b1;
        end
      end
      S_CHECK: begin
        w_busy = 1'b1;
        if (w_accept) begin
          w_next = S_EVAL;
        end else if (w_timeout) begin
          w_next  = S_ERROR;
          w_abort = 1'b1;
        end
      end
      S_EVAL: begin
        w_busy = 1'b1;
        w_next = w_match ? S_RUN : S_ERROR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum       <= '0;
      r_chk       <= '0;
      r_count     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ok        <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_we <= w_load_byte;
      if (w_start) begin
        r_sum   <= '0;
        r_count <= '0;
        r_ok    <= 1'b0;
        r_err   <= 1'b0;
      end
      if (w_load_byte) begin
        r_mem_addr  <= r_count[AW-1:0];
        r_mem_wdata <= in_data;
        r_sum       <= r_sum + in_data;
        r_count     <= r_count + 1'b1;
      end
      if ((r_state == S_CHECK) && w_accept) begin
        r_chk <= in_data;
      end
      if (r_state == S_EVAL) begin
        r_ok  <= w_match;
        r_err <= !w_match;
      end
      if (w_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_run    = (r_state == S_RUN);
  assign busy       = w_busy;
  assign load_ok    = r_ok;
  assign load_err   = r_err;
  assign byte_count = r_count;
endmodule

// File: tb/tb_program_loader.sv
// Randomised scoreboard bench for program_loader against a frame-level reference model.
module tb_program_loader;
  localparam int DEPTH = 16;
  localparam int TO    = 8;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_run;
  logic       busy;
  logic       load_ok;
  logic       load_err;
  logic [4:0] byte_count;

  program_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_run(cpu_run),
    .busy(busy), .load_ok(load_ok), .load_err(load_err), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; int data; int cyc; } wr_t;
  wr_t wq[$];
  int  rq[$];

  // Reference model: where we are in a frame plus the sticky results.
  int m_phase   = 0;   // 0 waiting for sync, 1 data bytes, 2 checksum byte
  int m_cnt     = 0;
  int m_sum     = 0;
  int m_ok      = 0;
  int m_err     = 0;
  int m_running = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_accept(input int b, input int c);
    if (m_phase == 0) begin
      if (b == SYNC) begin
        m_phase = 1; m_cnt = 0; m_sum = 0; m_ok = 0; m_err = 0; m_running = 0;
      end
    end else if (m_phase == 1) begin
      wq.push_back('{addr: m_cnt, data: b, cyc: c + 1});
      m_sum = (m_sum + b) % 256;
      m_cnt++;
      if (m_cnt == DEPTH) m_phase = 2;
    end else begin
      m_phase = 0;
      if (b == m_sum) begin
        m_ok = 1; m_running = 1;
        rq.push_back(c + 2);
      end else begin
        m_err = 1;
      end
    end
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_cnt = 0; m_sum = 0; m_ok = 0; m_err = 0; m_running = 0;
  endfunction

  // Monitor: pops expected writes and run releases as the DUT presents them.
  logic prev_run = 1'b0;
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wq.size() == 0) begin
        chk("spurious_mem_we", 32'(mem_we), 0);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", 32'(mem_addr), e.addr);
        chk("wr_data", 32'(mem_wdata), e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
    if (cpu_run === 1'b1 && !prev_run) begin
      if (rq.size() == 0) begin
        chk("spurious_run_rise", 32'(cpu_run), 0);
      end else begin
        chk("run_rise_cycle", cyc, rq.pop_front());
        chk("run_load_ok", 32'(load_ok), 1);
      end
    end
    prev_run = (cpu_run === 1'b1);
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b);
    int c;
    in_valid = 1'b1;
    in_data  = b;
    for (int g = 0; g < 20 && !in_ready; g++) @(negedge clk);
    if (!in_ready) begin
      chk("ready_wait_expired", 32'(in_ready), 1);
      in_valid = 1'b0;
      return;
    end
    c = cyc;
    @(posedge clk);
    model_accept(b, c);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_cpu_run"}, 32'(cpu_run), m_running);
    chk({tag, "_load_ok"}, 32'(load_ok), m_ok);
    chk({tag, "_load_err"}, 32'(load_err), m_err);
    chk({tag, "_busy"}, 32'(busy), (m_phase != 0) ? 1 : 0);
    chk({tag, "_byte_count"}, 32'(byte_count), m_cnt);
  endtask

  task automatic send_frame(input logic [7:0] d[DEPTH], input logic [7:0] cks, input int maxgap);
    send(SYNC);
    for (int i = 0; i < DEPTH; i++) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      send(d[i]);
    end
    repeat ($urandom_range(0, maxgap)) @(negedge clk);
    send(cks);
    chk("eval_in_ready_low", 32'(in_ready), 0);
  endtask

  function automatic logic [7:0] sum_of(input logic [7:0] d[DEPTH]);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < DEPTH; i++) s = s + d[i];
    return s;
  endfunction

  logic [7:0] frame[DEPTH];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 0);
    chk("reset_mem_we", 32'(mem_we), 0);
    chk("reset_mem_addr", 32'(mem_addr), 0);
    chk("reset_mem_wdata", 32'(mem_wdata), 0);
    check_status("reset");
    rst = 1'b0;
    #1 chk("post_reset_in_ready", 32'(in_ready), 1);
    @(negedge clk);

    // Junk before sync is dropped.
    send(8'h00);
    send(8'hFF);
    check_status("junk");

    // Good frame 01..10, checksum 88.
    for (int i = 0; i < DEPTH; i++) frame[i] = 8'(i + 1);
    send_frame(frame, 8'h88, 0);
    repeat (2) @(negedge clk);
    check_status("good");

    // Same frame, checksum 89.
    send_frame(frame, 8'h89, 0);
    repeat (2) @(negedge clk);
    check_status("badcks");

    // Sync byte as data at address 3.
    frame[3] = SYNC;
    send_frame(frame, sum_of(frame), 1);
    repeat (2) @(negedge clk);
    check_status("sync_in_data");

    // Reload from RUN: cpu_run drops right after the sync is taken.
    send(SYNC);
    chk("reload_cpu_run", 32'(cpu_run), 0);
    chk("reload_busy", 32'(busy), 1);
    for (int i = 0; i < DEPTH; i++) send(frame[i] ^ 8'h3C);
    for (int i = 0; i < DEPTH; i++) frame[i] = frame[i] ^ 8'h3C;
    send(sum_of(frame));
    // Byte offered during EVAL must wait for RUN; here it is a sync that starts a reload.
    send(SYNC);
    chk("held_sync_busy", 32'(busy), 1);
    chk("held_sync_cpu_run", 32'(cpu_run), 0);
    for (int i = 0; i < DEPTH; i++) send(frame[i]);
    send(sum_of(frame));
    repeat (2) @(negedge clk);
    check_status("held_sync");

    // Reset mid-frame after 7 data bytes.
    send(SYNC);
    for (int i = 0; i < 7; i++) send(8'(8'h40 + i));
    @(negedge clk);
    rst = 1'b1;
    #1 chk("midreset_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("midreset_mem_we", 32'(mem_we), 0);
    chk("midreset_mem_addr", 32'(mem_addr), 0);
    chk("midreset_mem_wdata", 32'(mem_wdata), 0);
    check_status("midreset");
    repeat (4) @(negedge clk);

`ifdef LOADER_TIMEOUT_EN
    // Stall of TO cycles inside a frame is an error; TO-1 is not.
    send(SYNC);
    for (int i = 0; i < 5; i++) send(8'(i));
    repeat (TO) @(negedge clk);
    model_reset();
    m_err = 1;
    check_status("timeout");
    send(SYNC);
    for (int i = 0; i < 5; i++) send(8'(i + 9));
    repeat (TO - 1) @(negedge clk);
    send(8'h77);
    chk("no_timeout_err", 32'(load_err), 0);
    chk("no_timeout_busy", 32'(busy), 1);
    for (int i = 6; i < DEPTH; i++) send(8'(i));
    send(8'(m_sum));
    repeat (2) @(negedge clk);
    check_status("after_stall");
`endif

    // Randomised frames with junk, gaps and occasional bad checksums.
    for (int f = 0; f < 12; f++) begin
      int nj;
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        logic [7:0] jb;
        jb = 8'($urandom_range(0, 255));
        if (jb == SYNC) jb = 8'h5A;
        send(jb);
      end
      for (int i = 0; i < DEPTH; i++) frame[i] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) frame[$urandom_range(0, DEPTH - 1)] = SYNC;
      if ($urandom_range(0, 3) == 0)
        send_frame(frame, sum_of(frame) + 8'($urandom_range(1, 255)), 2);
      else
        send_frame(frame, sum_of(frame), 2);
      repeat (2) @(negedge clk);
      check_status("rand");
    end

    repeat (3) @(negedge clk);
    chk("writes_outstanding", wq.size(), 0);
    chk("runs_outstanding", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
